ram_access_arbiter: RTL

- Shares the single-port 256x8 slave RAM between two command requesters: the SPI slave command path and a secondary debug/BIST port.
- Each requester issues the standard 10-bit RAM command words {cmd[1:0], payload[7:0]}: WRITE_ADD=0, WRITE_DATA=1, READ_ADD=2, READ_DATA=3.
- The block keeps separate write and read address registers per requester, so one requester cannot clobber the other's address.
- It round-robin arbitrates, sequences the RAM write/read cycles, and routes read data back to the requester that owns it.

---
 rtl/ram_access_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: shares one single-port RAM between two command requesters.
// Each requester sends {cmd[1:0], payload[7:0]} words and owns its own write and
// read address registers. Grants alternate round-robin when both requesters
// contend. Read data is routed back to the requester that issued the read.
`timescale 1ns/1ps

module ram_access_arbiter #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = $clog2(MEM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    input  logic [9:0]           req0_din,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [9:0]           req1_din,
    output logic                 req1_ready,
    output logic                 rsp0_valid,
    output logic [7:0]           rsp0_data,
    output logic                 rsp1_valid,
    output logic [7:0]           rsp1_data,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [7:0]           mem_wdata,
    input  logic [7:0]           mem_rdata,
    output logic                 busy
);

    localparam logic [1:0] CMD_WRITE_ADD  = 2'd0;
    localparam logic [1:0] CMD_WRITE_DATA = 2'd1;
    localparam logic [1:0] CMD_READ_ADD   = 2'd2;
    localparam logic [1:0] CMD_READ_DATA  = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEM_WR  = 2'd1,
        MEM_RD  = 2'd2,
        RD_WAIT = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic       last_grant_q;   // id of the most recently granted requester
    logic       owner_q;        // requester that owns the current memory cycle
    logic [7:0] wdata_q;        // write payload held for the MEM_WR cycle

    logic [1:0]                valid_all;
    logic [1:0][9:0]           din_all;
    logic [1:0]                grant;
    logic [9:0]                sel_din;
    logic [1:0][ADDR_SIZE-1:0] wr_addr_all;
    logic [1:0][ADDR_SIZE-1:0] rd_addr_all;
    logic [1:0]                rsp_valid_all;
    logic [1:0][7:0]           rsp_data_all;

    assign valid_all = {req1_valid, req0_valid};
    assign din_all   = {req1_din, req0_din};

    // Grant selection: only in IDLE, lone requester wins, contention goes to
    // whoever was not granted last. Reset masks grants so nothing is accepted.
    always_comb begin
        grant = 2'b00;
        if (state_q == IDLE && !rst) begin
            case (valid_all)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign sel_din    = grant[1] ? req1_din : req0_din;

    // State register plus the arbitration and command bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            wdata_q      <= 8'h00;
        end else begin
            state_q <= state_d;
            if (|grant) begin
                last_grant_q <= grant[1];
                owner_q      <= grant[1];
                wdata_q      <= sel_din[7:0];
            end
        end
    end

    // Next-state logic: address commands complete in IDLE, data commands
    // launch a one-cycle RAM access (reads add a wait cycle for RAM latency).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (|grant) begin
                    if (sel_din[9:8] == CMD_WRITE_DATA) begin
                        state_d = MEM_WR;
                    end else if (sel_din[9:8] == CMD_READ_DATA) begin
                        state_d = MEM_RD;
                    end
                end
            end
            MEM_WR:  state_d = IDLE;
            MEM_RD:  state_d = RD_WAIT;
            RD_WAIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode: RAM strobe and address/data only during access cycles,
    // zero otherwise so the bus is quiet when idle.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 8'h00;
        case (state_q)
            MEM_WR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = wr_addr_all[owner_q];
                mem_wdata = wdata_q;
            end
            MEM_RD: begin
                mem_en   = 1'b1;
                mem_addr = rd_addr_all[owner_q];
            end
            default: begin
                mem_en = 1'b0;
            end
        endcase
    end

    assign busy = (state_q != IDLE);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            localparam logic REQ_ID = 1'(gi);

            logic [ADDR_SIZE-1:0] wr_addr_q;
            logic [ADDR_SIZE-1:0] rd_addr_q;
            logic                 rsp_valid_q;
            logic [7:0]           rsp_data_q;
            logic                 rsp_capture;

            // Read data belongs to this requester when it owns the RD_WAIT cycle.
            assign rsp_capture = (state_q == RD_WAIT) && (owner_q == REQ_ID);

            // Per-requester address registers and response capture; a command
            // only ever touches the registers of the requester that sent it.
            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_addr_q   <= '0;
                    rd_addr_q   <= '0;
                    rsp_valid_q <= 1'b0;
                    rsp_data_q  <= 8'h00;
                end else begin
                    if (grant[gi] && din_all[gi][9:8] == CMD_WRITE_ADD) begin
                        wr_addr_q <= din_all[gi][ADDR_SIZE-1:0];
                    end
                    if (grant[gi] && din_all[gi][9:8] == CMD_READ_ADD) begin
                        rd_addr_q <= din_all[gi][ADDR_SIZE-1:0];
                    end
                    rsp_valid_q <= rsp_capture;
                    if (rsp_capture) begin
                        rsp_data_q <= mem_rdata;
                    end
                end
            end

            assign wr_addr_all[gi]   = wr_addr_q;
            assign rd_addr_all[gi]   = rd_addr_q;
            assign rsp_valid_all[gi] = rsp_valid_q;
            assign rsp_data_all[gi]  = rsp_data_q;
        end
    endgenerate

    assign rsp0_valid = rsp_valid_all[0];
    assign rsp0_data  = rsp_data_all[0];
    assign rsp1_valid = rsp_valid_all[1];
    assign rsp1_data  = rsp_data_all[1];

endmodule
